uart_cmd_responder: RTL and testbench

//  Device-side command engine of the UART register-access protocol. Parses host command

---
 rtl/uart_cmd_responder.sv | 258 +++++++++++++++++++++++++
 tb/tb_uart_cmd_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder
//   Device-side command engine for the UART register-access protocol.
//   Parses host frames (CMD, ADDR_H, ADDR_L, write data) from the rx byte
//   stream, issues single/burst 16-bit register writes or reads, and returns
//   an ack byte (write) or the read data MSB first (read) to the transmitter.
// Ports
//   clk_i / rst_i               clock, asynchronous active-high reset
//   rx_data_i / rx_valid_i      received byte with 1-cycle strobe
//   tx_data_o / tx_valid_o      byte to send, held until tx_ready_i
//   tx_ready_i                  transmitter accepts when valid & ready
//   reg_addr_o                  register offset (12 bits)
//   reg_wr_o / reg_wdata_o      1-cycle write strobe and its data
//   reg_rd_o / reg_rdata_i      1-cycle read strobe; data valid next cycle
//   busy_o                      high whenever a frame is in progress
//   frame_err_o                 1-cycle pulse on timeout or foreign address
module uart_cmd_responder #(
  parameter logic [3:0]  BASEADDR    = 4'h2,
  parameter logic [7:0]  ACK_BYTE    = 8'hA5,
  parameter logic [19:0] TIMEOUT_CYC = 20'd200000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [11:0] reg_addr_o,
  output logic        reg_wr_o,
  output logic        reg_rd_o,
  output logic [15:0] reg_wdata_o,
  input  logic [15:0] reg_rdata_i,
  output logic        busy_o,
  output logic        frame_err_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_WD_H, S_WD_L, S_WRITE, S_ACK,
    S_READ, S_RWAIT, S_TX_H, S_TX_L, S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic        rw_q, rw_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  beat_q, beat_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  addr_h_q, addr_h_d;
  logic [7:0]  wd_hi_q, wd_hi_d;
  logic [7:0]  rdata_lo_q, rdata_lo_d;
  logic [5:0]  drain_q, drain_d;
  logic [19:0] timer_q, timer_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic [11:0] reg_addr_q, reg_addr_d;
  logic        reg_wr_q, reg_wr_d;
  logic        reg_rd_q, reg_rd_d;
  logic [15:0] reg_wdata_q, reg_wdata_d;
  logic        frame_err_q, frame_err_d;

  logic timed;
  logic timeout;
  logic tx_accept;

  // Only states that wait on the host are timed; waiting on the
  // transmitter or the bus never times out.
  assign timed = (state_q == S_ADDR_H) || (state_q == S_ADDR_L) ||
                 (state_q == S_WD_H)   || (state_q == S_WD_L)   ||
                 (state_q == S_DRAIN);
  // A byte arriving in the expiry cycle wins over the timeout.
  assign timeout   = timed && !rx_valid_i && ((timer_q + 20'd1) >= TIMEOUT_CYC);
  assign tx_accept = tx_valid_q && tx_ready_i;

  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    len_d       = len_q;
    beat_d      = beat_q;
    addr_d      = addr_q;
    addr_h_d    = addr_h_q;
    wd_hi_d     = wd_hi_q;
    rdata_lo_d  = rdata_lo_q;
    drain_d     = drain_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    frame_err_d = 1'b0;
    timer_d     = (timed && !rx_valid_i) ? timer_q + 20'd1 : 20'd0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid_i) begin
          rw_d    = rx_data_i[7];
          len_d   = rx_data_i[3:0];
          beat_d  = 4'd0;
          state_d = S_ADDR_H;
        end
      end
      S_ADDR_H: begin
        if (rx_valid_i) begin
          addr_h_d = rx_data_i;
          state_d  = S_ADDR_L;
        end
      end
      S_ADDR_L: begin
        if (rx_valid_i) begin
          addr_d = {addr_h_q[3:0], rx_data_i};
          if (addr_h_q[7:4] != BASEADDR) begin
            frame_err_d = 1'b1;
            // A foreign write still carries 2*(len+1) data bytes to swallow;
            // a foreign read carries none.
            if (rw_q) begin
              drain_d = {1'b0, len_q, 1'b0} + 6'd2;
              state_d = S_DRAIN;
            end else begin
              state_d = S_IDLE;
            end
          end else if (rw_q) begin
            state_d = S_WD_H;
          end else begin
            // Strobe is registered, so it is visible during S_READ and the
            // data arrives during S_RWAIT.
            reg_rd_d   = 1'b1;
            reg_addr_d = {addr_h_q[3:0], rx_data_i};
            state_d    = S_READ;
          end
        end
      end
      S_WD_H: begin
        if (rx_valid_i) begin
          wd_hi_d = rx_data_i;
          state_d = S_WD_L;
        end
      end
      S_WD_L: begin
        if (rx_valid_i) begin
          reg_wr_d    = 1'b1;
          reg_addr_d  = addr_q;
          reg_wdata_d = {wd_hi_q, rx_data_i};
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + 12'd1;
        beat_d = beat_q + 4'd1;
        if (beat_q == len_q) begin
          tx_data_d  = ACK_BYTE;
          tx_valid_d = 1'b1;
          state_d    = S_ACK;
        end else begin
          state_d = S_WD_H;
        end
      end
      S_ACK: begin
        if (tx_accept) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_READ: begin
        state_d = S_RWAIT;
      end
      S_RWAIT: begin
        rdata_lo_d = reg_rdata_i[7:0];
        tx_data_d  = reg_rdata_i[15:8];
        tx_valid_d = 1'b1;
        state_d    = S_TX_H;
      end
      S_TX_H: begin
        if (tx_accept) begin
          tx_data_d = rdata_lo_q;
          state_d   = S_TX_L;
        end
      end
      S_TX_L: begin
        if (tx_accept) begin
          tx_valid_d = 1'b0;
          addr_d     = addr_q + 12'd1;
          beat_d     = beat_q + 4'd1;
          if (beat_q == len_q) begin
            state_d = S_IDLE;
          end else begin
            reg_rd_d   = 1'b1;
            reg_addr_d = addr_q + 12'd1;
            state_d    = S_READ;
          end
        end
      end
      S_DRAIN: begin
        if (rx_valid_i) begin
          drain_d = drain_q - 6'd1;
          if (drain_q == 6'd1) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      frame_err_d = 1'b1;
      timer_d     = 20'd0;
      state_d     = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      rw_q        <= 1'b0;
      len_q       <= 4'd0;
      beat_q      <= 4'd0;
      addr_q      <= 12'd0;
      addr_h_q    <= 8'd0;
      wd_hi_q     <= 8'd0;
      rdata_lo_q  <= 8'd0;
      drain_q     <= 6'd0;
      timer_q     <= 20'd0;
      tx_data_q   <= 8'd0;
      tx_valid_q  <= 1'b0;
      reg_addr_q  <= 12'd0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      reg_wdata_q <= 16'd0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      addr_q      <= addr_d;
      addr_h_q    <= addr_h_d;
      wd_hi_q     <= wd_hi_d;
      rdata_lo_q  <= rdata_lo_d;
      drain_q     <= drain_d;
      timer_q     <= timer_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      reg_addr_q  <= reg_addr_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      reg_wdata_q <= reg_wdata_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign tx_data_o   = tx_data_q;
  assign tx_valid_o  = tx_valid_q;
  assign reg_addr_o  = reg_addr_q;
  assign reg_wr_o    = reg_wr_q;
  assign reg_rd_o    = reg_rd_q;
  assign reg_wdata_o = reg_wdata_q;
  assign frame_err_o = frame_err_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder: host frames are driven byte by byte, a
// register stub answers bus reads, and expected bus writes, bus reads and
// tx bytes are queued at stimulus time and compared as the DUT emits them.
module tb_uart_cmd_responder;

  localparam logic [19:0] TO_CYC = 20'd300;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [11:0] reg_addr_o;
  logic        reg_wr_o;
  logic        reg_rd_o;
  logic [15:0] reg_wdata_o;
  logic [15:0] reg_rdata_i;
  logic        busy_o;
  logic        frame_err_o;

  uart_cmd_responder #(
    .BASEADDR(4'h2), .ACK_BYTE(8'hA5), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .reg_addr_o(reg_addr_o), .reg_wr_o(reg_wr_o), .reg_rd_o(reg_rd_o),
    .reg_wdata_o(reg_wdata_o), .reg_rdata_i(reg_rdata_i),
    .busy_o(busy_o), .frame_err_o(frame_err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [27:0] exp_wr_q[$];
  logic [11:0] exp_rd_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [15:0] exp_mem  [0:4095];
  logic [15:0] stub_mem [0:4095];
  logic [15:0] wbuf [0:15];
  int          err_seen = 0;
  int          err_exp  = 0;
  logic        toggle_en = 1'b0;

  logic [27:0] e_wr;
  logic [11:0] e_rd;
  logic [7:0]  e_tx;
  logic        stalled_prev = 1'b0;
  logic [7:0]  held_data = 8'd0;

  // Monitor / scoreboard: everything sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (reg_wr_o) begin
          if (exp_wr_q.size() == 0) begin
            check("unexpected_wr", 32'(reg_addr_o), 32'hFFFF_FFFF);
          end else begin
            e_wr = exp_wr_q.pop_front();
            check("wr_addr", 32'(reg_addr_o), 32'(e_wr[27:16]));
            check("wr_data", 32'(reg_wdata_o), 32'(e_wr[15:0]));
            $display("bus write addr=%03h data=%04h", reg_addr_o, reg_wdata_o);
          end
          stub_mem[reg_addr_o] = reg_wdata_o;
        end
        if (reg_rd_o) begin
          if (exp_rd_q.size() == 0) begin
            check("unexpected_rd", 32'(reg_addr_o), 32'hFFFF_FFFF);
          end else begin
            e_rd = exp_rd_q.pop_front();
            check("rd_addr", 32'(reg_addr_o), 32'(e_rd));
            $display("bus read  addr=%03h", reg_addr_o);
          end
        end
        if (stalled_prev) begin
          check("tx_hold", {23'd0, tx_valid_o, tx_data_o}, {23'd0, 1'b1, held_data});
        end
        if (tx_valid_o && tx_ready_i) begin
          if (exp_tx_q.size() == 0) begin
            check("unexpected_tx", 32'(tx_data_o), 32'hFFFF_FFFF);
          end else begin
            e_tx = exp_tx_q.pop_front();
            check("tx_byte", 32'(tx_data_o), 32'(e_tx));
            $display("tx byte %02h", tx_data_o);
          end
        end
        stalled_prev = tx_valid_o && !tx_ready_i;
        held_data    = tx_data_o;
        if (frame_err_o) err_seen++;
      end else begin
        stalled_prev = 1'b0;
      end
    end
  end

  // Register stub: read data valid only in the cycle after the strobe.
  initial begin
    reg_rdata_i = 16'hDEAD;
    forever begin
      @(negedge clk_i);
      if (reg_rd_o && !rst_i) begin
        @(posedge clk_i); #1;
        reg_rdata_i = stub_mem[reg_addr_o];
        @(posedge clk_i); #1;
        reg_rdata_i = 16'hDEAD;
      end
    end
  end

  // Transmitter back-pressure.
  initial begin
    tx_ready_i = 1'b1;
    forever begin
      @(posedge clk_i); #2;
      tx_ready_i = toggle_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(posedge clk_i); #1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [3:0] len);
    logic [11:0] a;
    $display("frame write addr=%04h len=%0d", addr, len);
    if (addr[15:12] == 4'h2) begin
      for (int i = 0; i <= int'(len); i++) begin
        a = addr[11:0] + 12'(i);
        exp_wr_q.push_back({a, wbuf[i]});
        exp_mem[a] = wbuf[i];
      end
      exp_tx_q.push_back(8'hA5);
    end else begin
      err_exp++;
    end
    send_byte({1'b1, 3'b000, len});
    send_byte(addr[15:8]);
    send_byte(addr[7:0]);
    for (int i = 0; i <= int'(len); i++) begin
      send_byte(wbuf[i][15:8]);
      send_byte(wbuf[i][7:0]);
    end
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [3:0] len);
    logic [11:0] a;
    $display("frame read  addr=%04h len=%0d", addr, len);
    for (int i = 0; i <= int'(len); i++) begin
      a = addr[11:0] + 12'(i);
      exp_rd_q.push_back(a);
      exp_tx_q.push_back(exp_mem[a][15:8]);
      exp_tx_q.push_back(exp_mem[a][7:0]);
    end
    send_byte({1'b0, 3'b000, len});
    send_byte(addr[15:8]);
    send_byte(addr[7:0]);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy_o || exp_tx_q.size() != 0) && n < 3000) begin
      @(posedge clk_i); #1;
      n++;
    end
    check({tag, "_done_in_time"}, 32'(n < 3000), 32'd1);
    repeat (3) @(posedge clk_i);
    #1;
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_wr_left"}, 32'(exp_wr_q.size()), 32'd0);
    check({tag, "_rd_left"}, 32'(exp_rd_q.size()), 32'd0);
    check({tag, "_err_count"}, 32'(err_seen), 32'(err_exp));
  endtask

  initial begin
    int n;
    rst_i      = 1'b1;
    rx_data_i  = 8'h00;
    rx_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_outputs",
          {3'd0, tx_valid_o, reg_wr_o, reg_rd_o, busy_o, frame_err_o, tx_data_o, 4'd0, reg_addr_o},
          32'd0);
    check("rst_wdata", 32'(reg_wdata_o), 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // T1: single write
    wbuf[0] = 16'h8888;
    do_write(16'h2008, 4'd0);
    wait_idle("t1");

    // T2: single read back
    do_read(16'h2008, 4'd0);
    wait_idle("t2");

    // T3: 16-beat burst write then burst read
    for (int i = 0; i < 15; i++) wbuf[i] = 16'h1111 * 16'(i + 1);
    wbuf[15] = 16'hABCD;
    do_write(16'h2001, 4'd15);
    wait_idle("t3w");
    do_read(16'h2001, 4'd15);
    wait_idle("t3r");

    // T4: foreign base address, write data drained silently
    wbuf[0] = 16'h1234;
    wbuf[1] = 16'h5678;
    do_write(16'h3008, 4'd1);
    wait_idle("t4");

    // T5: timeout after CMD + ADDR_H, then a normal frame
    $display("frame partial then silence");
    send_byte(8'h80);
    send_byte(8'h20);
    err_exp++;
    n = 0;
    while (err_seen < err_exp && n < int'(TO_CYC) + 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("t5_timeout_seen", 32'(err_seen), 32'(err_exp));
    check("t5_busy", 32'(busy_o), 32'd0);
    wbuf[0] = 16'h4242;
    do_write(16'h2010, 4'd0);
    wait_idle("t5");

    // T6: burst read across the address wrap with tx back-pressure
    wbuf[0] = 16'h0AF1;
    wbuf[1] = 16'hB2C3;
    wbuf[2] = 16'hD4E5;
    wbuf[3] = 16'hF607;
    do_write(16'h2FFE, 4'd3);
    wait_idle("t6w");
    toggle_en = 1'b1;
    do_read(16'h2FFE, 4'd3);
    wait_idle("t6r");
    toggle_en = 1'b0;

    // Reset in the middle of a write frame: nothing may follow.
    $display("frame write aborted by reset");
    send_byte(8'h80);
    send_byte(8'h20);
    send_byte(8'h08);
    send_byte(8'h77);
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_tx_valid", 32'(tx_valid_o), 32'd0);
    send_byte(8'h66);
    repeat (20) @(posedge clk_i);
    #1;
    check("abort_busy_after", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("abort_no_wr_or_tx", 32'(exp_wr_q.size() + exp_tx_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
